// File: rtl/adc_frame_tx_pkg.sv
// Shared types and constants for the chirp-framed ADC transmitter.
// Optional statistics counters are enabled with the ADC_TX_STATS_EN macro.
package adc_frame_tx_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_GAP_W  = 8;

  localparam logic PATTERN_SRC  = 1'b0;
  localparam logic PATTERN_RAMP = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHIRP = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } tx_state_e;

  // Bring-up ramp word: chirp index in the upper half, sample index in the lower.
  function automatic logic [31:0] ramp_word(input logic [15:0] chirp, input logic [15:0] sample);
    return {chirp, sample};
  endfunction

endpackage

// File: rtl/adc_frame_tx_cnt.sv
// Two-level sample/chirp position counter with first/last flags.
// Flags decode the registered indices, so they are valid in the cycle a beat is formed.
module adc_frame_tx_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [CNT_W-1:0] sample_num,
  input  logic [CNT_W-1:0] chirp_num,
  output logic [CNT_W-1:0] sample_idx,
  output logic [CNT_W-1:0] chirp_idx,
  output logic             first_sample,
  output logic             last_sample,
  output logic             last_chirp
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] sample_idx_r;
  logic [CNT_W-1:0] chirp_idx_r;

  // Position registers; the sample index wraps into the chirp index on the last beat.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sample_idx_r <= '0;
      chirp_idx_r  <= '0;
    end else if (adv) begin
      if (last_sample) begin
        sample_idx_r <= '0;
        chirp_idx_r  <= last_chirp ? '0 : chirp_idx_r + CNT_ONE;
      end else begin
        sample_idx_r <= sample_idx_r + CNT_ONE;
        chirp_idx_r  <= chirp_idx_r;
      end
    end else begin
      sample_idx_r <= sample_idx_r;
      chirp_idx_r  <= chirp_idx_r;
    end
  end

  assign sample_idx   = sample_idx_r;
  assign chirp_idx    = chirp_idx_r;
  assign first_sample = (sample_idx_r == '0);
  assign last_sample  = (sample_idx_r == sample_num - CNT_ONE);
  assign last_chirp   = (chirp_idx_r == chirp_num - CNT_ONE);

endmodule

// File: rtl/adc_frame_tx.sv
// Chirp-framed ADC stream transmitter: source passthrough or internal ramp, per CPI.
// Define ADC_TX_STATS_EN to build the underrun and frame statistics counters.
module adc_frame_tx
  import adc_frame_tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GAP_W  = DEF_GAP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cpib,
  input  logic              i_cpie,
  input  logic [CNT_W-1:0]  sample_num,
  input  logic [CNT_W-1:0]  chirp_num,
  input  logic [GAP_W-1:0]  chirp_gap,
  input  logic              pattern_sel,
  input  logic [DATA_W-1:0] src_tdata,
  input  logic              src_tvalid,
  output logic              src_tready,
  output logic              adc_data_valid,
  output logic [DATA_W-1:0] adc_data,
  output logic              adc_data_sop,
  output logic              adc_data_eop,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_trunc,
  output logic              cfg_err,
  output logic [15:0]       underrun_cnt,
  output logic [15:0]       frame_cnt
);

  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  tx_state_e         state_r, state_nx;
  logic [CNT_W-1:0]  sample_num_r, sample_num_nx;
  logic [CNT_W-1:0]  chirp_num_r, chirp_num_nx;
  logic [GAP_W-1:0]  chirp_gap_r, chirp_gap_nx;
  logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_nx;
  logic              pattern_r, pattern_nx;
  logic              abort_r, abort_nx;

  logic              valid_r, valid_nx;
  logic [DATA_W-1:0] data_r, data_nx;
  logic              sop_r, sop_nx;
  logic              eop_r, eop_nx;
  logic              ready_r, ready_nx;
  logic              busy_r, busy_nx;
  logic              done_r, done_nx;
  logic              trunc_r, trunc_nx;
  logic              cfg_err_r, cfg_err_nx;

  logic              beat_s;
  logic              abort_now_s;
  logic              cfg_ok_s;
  logic              cnt_clr_s;
  logic [CNT_W-1:0]  sample_idx_s, chirp_idx_s;
  logic              first_sample_s, last_sample_s, last_chirp_s;

  assign cfg_ok_s    = (sample_num != '0) && (chirp_num != '0);
  assign abort_now_s = abort_r | i_cpie;
  assign beat_s      = (state_r == CHIRP) && ((pattern_r == PATTERN_RAMP) || src_tvalid);
  assign cnt_clr_s   = (state_r == LOAD);

  adc_frame_tx_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .clr          (cnt_clr_s),
    .adv          (beat_s),
    .sample_num   (sample_num_r),
    .chirp_num    (chirp_num_r),
    .sample_idx   (sample_idx_s),
    .chirp_idx    (chirp_idx_s),
    .first_sample (first_sample_s),
    .last_sample  (last_sample_s),
    .last_chirp   (last_chirp_s)
  );

  // Next-state, latched configuration and next values of every registered output.
  always_comb begin
    state_nx      = state_r;
    sample_num_nx = sample_num_r;
    chirp_num_nx  = chirp_num_r;
    chirp_gap_nx  = chirp_gap_r;
    pattern_nx    = pattern_r;
    abort_nx      = abort_r;
    trunc_nx      = trunc_r;
    gap_cnt_nx    = '0;
    cfg_err_nx    = 1'b0;

    case (state_r)
      IDLE: begin
        abort_nx = 1'b0;
        if (i_cpib) begin
          if (cfg_ok_s) begin
            state_nx = LOAD;
            trunc_nx = 1'b0;
          end else begin
            cfg_err_nx = 1'b1;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      LOAD: begin
        sample_num_nx = sample_num;
        chirp_num_nx  = chirp_num;
        chirp_gap_nx  = chirp_gap;
        pattern_nx    = pattern_sel;
        abort_nx      = abort_now_s;
        state_nx      = CHIRP;
      end
      CHIRP: begin
        abort_nx = abort_now_s;
        // A chirp is never cut: the exit decision is taken only on the eop beat.
        if (beat_s && last_sample_s) begin
          if (last_chirp_s || abort_now_s) begin
            state_nx = DONE;
            trunc_nx = trunc_r | abort_now_s;
          end else if (chirp_gap_r == '0) begin
            state_nx = CHIRP;
          end else begin
            state_nx = GAP;
          end
        end else begin
          state_nx = CHIRP;
        end
      end
      GAP: begin
        abort_nx = abort_now_s;
        if (abort_now_s) begin
          state_nx = DONE;
          trunc_nx = 1'b1;
        end else if (gap_cnt_r == chirp_gap_r - GAP_ONE) begin
          state_nx = CHIRP;
        end else begin
          state_nx   = GAP;
          gap_cnt_nx = gap_cnt_r + GAP_ONE;
        end
      end
      DONE: begin
        abort_nx = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        abort_nx = 1'b0;
        state_nx = IDLE;
      end
    endcase

    valid_nx = beat_s;
    sop_nx   = beat_s & first_sample_s;
    eop_nx   = beat_s & last_sample_s;
    if (!beat_s) begin
      data_nx = '0;
    end else if (pattern_r == PATTERN_RAMP) begin
      data_nx = DATA_W'(ramp_word(16'(chirp_idx_s), 16'(sample_idx_s)));
    end else begin
      data_nx = src_tdata;
    end

    // Outputs follow the next state so they line up with the state they describe.
    ready_nx = (state_nx == CHIRP) && (pattern_nx == PATTERN_SRC);
    busy_nx  = (state_nx != IDLE);
    done_nx  = (state_nx == DONE);
  end

  // State, configuration and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      sample_num_r <= '0;
      chirp_num_r  <= '0;
      chirp_gap_r  <= '0;
      gap_cnt_r    <= '0;
      pattern_r    <= PATTERN_SRC;
      abort_r      <= 1'b0;
      valid_r      <= 1'b0;
      data_r       <= '0;
      sop_r        <= 1'b0;
      eop_r        <= 1'b0;
      ready_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      trunc_r      <= 1'b0;
      cfg_err_r    <= 1'b0;
    end else begin
      state_r      <= state_nx;
      sample_num_r <= sample_num_nx;
      chirp_num_r  <= chirp_num_nx;
      chirp_gap_r  <= chirp_gap_nx;
      gap_cnt_r    <= gap_cnt_nx;
      pattern_r    <= pattern_nx;
      abort_r      <= abort_nx;
      valid_r      <= valid_nx;
      data_r       <= data_nx;
      sop_r        <= sop_nx;
      eop_r        <= eop_nx;
      ready_r      <= ready_nx;
      busy_r       <= busy_nx;
      done_r       <= done_nx;
      trunc_r      <= trunc_nx;
      cfg_err_r    <= cfg_err_nx;
    end
  end

  assign src_tready     = ready_r;
  assign adc_data_valid = valid_r;
  assign adc_data       = data_r;
  assign adc_data_sop   = sop_r;
  assign adc_data_eop   = eop_r;
  assign busy           = busy_r;
  assign frame_done     = done_r;
  assign frame_trunc    = trunc_r;
  assign cfg_err        = cfg_err_r;

`ifdef ADC_TX_STATS_EN
  logic [15:0] underrun_r;
  logic [15:0] frame_cnt_r;

  // Saturating source-stall counter and completed-CPI counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_r  <= 16'd0;
      frame_cnt_r <= 16'd0;
    end else begin
      if ((state_r == CHIRP) && (pattern_r == PATTERN_SRC) && !src_tvalid &&
          (underrun_r != 16'hFFFF)) begin
        underrun_r <= underrun_r + 16'd1;
      end else begin
        underrun_r <= underrun_r;
      end
      if ((state_nx == DONE) && (state_r != DONE)) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  assign underrun_cnt = underrun_r;
  assign frame_cnt    = frame_cnt_r;
`else
  assign underrun_cnt = 16'd0;
  assign frame_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_adc_frame_tx.sv
// Directed self-checking bench for adc_frame_tx: ramp, source stall, abort, bad config,
// ignored re-trigger and mid-frame reset. Statistics expectations track ADC_TX_STATS_EN.
module tb_adc_frame_tx;

`ifdef ADC_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cpib = 1'b0;
  logic        i_cpie = 1'b0;
  logic [15:0] sample_num = 16'd0;
  logic [15:0] chirp_num = 16'd0;
  logic [7:0]  chirp_gap = 8'd0;
  logic        pattern_sel = 1'b0;
  logic [31:0] src_tdata = 32'd0;
  logic        src_tvalid = 1'b0;
  logic        src_tready;
  logic        adc_data_valid;
  logic [31:0] adc_data;
  logic        adc_data_sop;
  logic        adc_data_eop;
  logic        busy;
  logic        frame_done;
  logic        frame_trunc;
  logic        cfg_err;
  logic [15:0] underrun_cnt;
  logic [15:0] frame_cnt;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int cyc = 0;

  logic [31:0] beat_data_q[$];
  bit          beat_sop_q[$];
  bit          beat_eop_q[$];
  int          beat_cyc_q[$];
  int          done_seen = 0;
  int          err_seen = 0;
  int          busy_seen = 0;

  adc_frame_tx dut (
    .clk            (clk),
    .rst            (rst),
    .i_cpib         (i_cpib),
    .i_cpie         (i_cpie),
    .sample_num     (sample_num),
    .chirp_num      (chirp_num),
    .chirp_gap      (chirp_gap),
    .pattern_sel    (pattern_sel),
    .src_tdata      (src_tdata),
    .src_tvalid     (src_tvalid),
    .src_tready     (src_tready),
    .adc_data_valid (adc_data_valid),
    .adc_data       (adc_data),
    .adc_data_sop   (adc_data_sop),
    .adc_data_eop   (adc_data_eop),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_trunc    (frame_trunc),
    .cfg_err        (cfg_err),
    .underrun_cnt   (underrun_cnt),
    .frame_cnt      (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output beat and pulse on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (adc_data_valid) begin
      beat_data_q.push_back(adc_data);
      beat_sop_q.push_back(adc_data_sop);
      beat_eop_q.push_back(adc_data_eop);
      beat_cyc_q.push_back(cyc);
    end
    if (frame_done) done_seen <= done_seen + 1;
    if (cfg_err)    err_seen  <= err_seen + 1;
    if (busy)       busy_seen <= busy_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_cpib(input logic [15:0] sn, input logic [15:0] cn, input logic [7:0] gap,
                            input logic pat, output int n0);
    @(posedge clk);
    #1;
    sample_num  = sn;
    chirp_num   = cn;
    chirp_gap   = gap;
    pattern_sel = pat;
    i_cpib      = 1'b1;
    n0          = cyc;
    @(posedge clk);
    #1;
    i_cpib = 1'b0;
  endtask

  initial begin
    int n0, b0, d0, e0, bz0, k, stall;
    bit hs;
    logic [15:0] fc_exp;

    // Reset state
    tick(3);
    check("rst_valid", {31'd0, adc_data_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tready", {31'd0, src_tready}, 32'd0);
    check("rst_trunc", {31'd0, frame_trunc}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    rst = 1'b0;
    tick(2);
    fc_exp = 16'd0;

    // Ramp 4 x 3, gap 2; config inputs change after LOAD and must be ignored
    b0 = beat_data_q.size(); d0 = done_seen;
    pulse_cpib(16'd4, 16'd3, 8'd2, 1'b1, n0);
    tick(1);
    sample_num = 16'd9; chirp_num = 16'd1; chirp_gap = 8'd0;
    tick(30);
    check("ramp_beats", beat_data_q.size() - b0, 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (b0 + i < beat_data_q.size()) begin
        check("ramp_data", beat_data_q[b0+i], ((i / 4) << 16) | (i % 4));
        check("ramp_sop", {31'd0, beat_sop_q[b0+i]}, {31'd0, (i % 4) == 0});
        check("ramp_eop", {31'd0, beat_eop_q[b0+i]}, {31'd0, (i % 4) == 3});
      end
    end
    if (beat_cyc_q.size() >= b0 + 12) begin
      check("ramp_latency", beat_cyc_q[b0] - n0, 32'd3);
      check("ramp_inchirp", beat_cyc_q[b0+1] - beat_cyc_q[b0], 32'd1);
      check("ramp_gap0", beat_cyc_q[b0+4] - beat_cyc_q[b0+3], 32'd3);
      check("ramp_gap1", beat_cyc_q[b0+8] - beat_cyc_q[b0+7], 32'd3);
    end
    check("ramp_done", done_seen - d0, 32'd1);
    fc_exp = fc_exp + 16'd1;
    check("ramp_frame_cnt", {16'd0, frame_cnt}, STATS ? {16'd0, fc_exp} : 32'd0);
    check("ramp_busy_end", {31'd0, busy}, 32'd0);
    check("ramp_trunc", {31'd0, frame_trunc}, 32'd0);

    // Source mode 8 x 1 with a 3-cycle stall after the third beat
    b0 = beat_data_q.size(); d0 = done_seen;
    src_tvalid = 1'b1;
    src_tdata  = 32'h1234_5600;
    k = 0; stall = 0;
    pulse_cpib(16'd8, 16'd1, 8'd0, 1'b0, n0);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      hs = src_tvalid && src_tready;
      @(posedge clk);
      #1;
      if (hs) k++;
      src_tdata = 32'h1234_5600 + k;
      if (k >= 8) begin
        src_tvalid = 1'b0;
      end else if (k == 3 && stall < 3) begin
        src_tvalid = 1'b0;
        stall++;
      end else begin
        src_tvalid = 1'b1;
      end
    end
    check("src_beats", beat_data_q.size() - b0, 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (b0 + i < beat_data_q.size()) begin
        check("src_data", beat_data_q[b0+i], 32'h1234_5600 + i);
        check("src_eop", {31'd0, beat_eop_q[b0+i]}, {31'd0, i == 7});
      end
    end
    if (beat_sop_q.size() >= b0 + 8) begin
      check("src_sop", {31'd0, beat_sop_q[b0]}, 32'd1);
      check("src_stall_gap", beat_cyc_q[b0+3] - beat_cyc_q[b0+2], 32'd4);
    end
    check("src_underrun", {16'd0, underrun_cnt}, STATS ? 32'd3 : 32'd0);
    check("src_done", done_seen - d0, 32'd1);
    check("src_tready_idle", {31'd0, src_tready}, 32'd0);
    fc_exp = fc_exp + 16'd1;

    // Abort requested while beat 2 of chirp 0 is formed: chirp 0 completes, nothing more
    b0 = beat_data_q.size(); d0 = done_seen;
    pulse_cpib(16'd4, 16'd5, 8'd1, 1'b1, n0);
    tick(3);
    i_cpie = 1'b1;
    tick(1);
    i_cpie = 1'b0;
    tick(20);
    check("abort_beats", beat_data_q.size() - b0, 32'd4);
    if (beat_data_q.size() >= b0 + 4) begin
      check("abort_last_data", beat_data_q[b0+3], 32'h0000_0003);
      check("abort_last_eop", {31'd0, beat_eop_q[b0+3]}, 32'd1);
    end
    check("abort_done", done_seen - d0, 32'd1);
    check("abort_trunc", {31'd0, frame_trunc}, 32'd1);
    fc_exp = fc_exp + 16'd1;
    check("abort_frame_cnt", {16'd0, frame_cnt}, STATS ? {16'd0, fc_exp} : 32'd0);

    // Rejected CPI: sample_num = 0
    b0 = beat_data_q.size(); e0 = err_seen; bz0 = busy_seen;
    pulse_cpib(16'd0, 16'd3, 8'd0, 1'b1, n0);
    tick(8);
    check("cfg_err_pulse", err_seen - e0, 32'd1);
    check("cfg_err_busy", busy_seen - bz0, 32'd0);
    check("cfg_err_beats", beat_data_q.size() - b0, 32'd0);
    check("cfg_err_trunc_sticky", {31'd0, frame_trunc}, 32'd1);

    // Second i_cpib while busy is ignored
    b0 = beat_data_q.size(); d0 = done_seen; e0 = err_seen;
    pulse_cpib(16'd2, 16'd2, 8'd0, 1'b1, n0);
    tick(2);
    pulse_cpib(16'd2, 16'd2, 8'd0, 1'b1, n0);
    tick(20);
    check("retrig_beats", beat_data_q.size() - b0, 32'd4);
    if (beat_data_q.size() >= b0 + 4) begin
      check("retrig_last_data", beat_data_q[b0+3], 32'h0001_0001);
    end
    check("retrig_done", done_seen - d0, 32'd1);
    check("retrig_no_err", err_seen - e0, 32'd0);
    check("retrig_trunc_clr", {31'd0, frame_trunc}, 32'd0);
    fc_exp = fc_exp + 16'd1;
    check("retrig_frame_cnt", {16'd0, frame_cnt}, STATS ? {16'd0, fc_exp} : 32'd0);

    // Reset mid-chirp, then a clean restart
    pulse_cpib(16'd4, 16'd2, 8'd0, 1'b1, n0);
    tick(3);
    check("pre_rst_valid", {31'd0, adc_data_valid}, 32'd1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_valid", {31'd0, adc_data_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_data", adc_data, 32'd0);
    check("mid_rst_eop", {31'd0, adc_data_eop}, 32'd0);
    rst = 1'b0;
    b0 = beat_data_q.size(); d0 = done_seen;
    tick(5);
    check("post_rst_quiet", beat_data_q.size() - b0, 32'd0);
    pulse_cpib(16'd4, 16'd1, 8'd0, 1'b1, n0);
    tick(12);
    check("restart_beats", beat_data_q.size() - b0, 32'd4);
    if (beat_data_q.size() >= b0 + 4) begin
      check("restart_sop", {31'd0, beat_sop_q[b0]}, 32'd1);
      check("restart_data0", beat_data_q[b0], 32'd0);
      check("restart_eop", {31'd0, beat_eop_q[b0+3]}, 32'd1);
    end
    check("restart_done", done_seen - d0, 32'd1);
    check("restart_frame_cnt", {16'd0, frame_cnt}, STATS ? 32'd1 : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule

// File: doc/adc_frame_tx.md
Name: adc_frame_tx

Overview:
- Transmitter end of the chirp-framed ADC stream consumed by the range-Doppler chain (adc_data_valid / adc_data / adc_data_sop / adc_data_eop).
- On each CPI-begin pulse, emits chirp_num chirps of sample_num beats each, with sop on the first beat and eop on the last beat of every chirp.
- Data comes either from an upstream AXI-stream source (live ADC FIFO) or from an internal ramp pattern for bring-up and regression.
- Sits between the ADC capture FIFO and the range-window stage.

Parameters:
- DATA_W, 32, beat width; {Q[15:0], I[15:0]} in source mode.
- CNT_W, 16, width of sample/chirp counters and config inputs.
- GAP_W, 8, width of the inter-chirp idle-gap config.

Ports:
- clk  in  1  system clock, 160 MHz.
- rst  in  1  synchronous, active-high reset.
- i_cpib  in  1  CPI-begin pulse, one cycle.
- i_cpie  in  1  CPI-end pulse; requests early termination.
- sample_num  in  CNT_W  beats per chirp.
- chirp_num  in  CNT_W  chirps per CPI.
- chirp_gap  in  GAP_W  idle cycles between eop and the next sop.
- pattern_sel  in  1  0 = source passthrough, 1 = internal ramp.
- src_tdata  in  DATA_W  upstream sample.
- src_tvalid  in  1  upstream valid.
- src_tready  out  1  upstream ready.
- adc_data_valid  out  1  output beat valid; no backpressure.
- adc_data  out  DATA_W  output beat.
- adc_data_sop  out  1  first beat of a chirp.
- adc_data_eop  out  1  last beat of a chirp.
- busy  out  1  high from LOAD through DONE.
- frame_done  out  1  one-cycle pulse at end of CPI.
- frame_trunc  out  1  sticky until next accepted i_cpib; CPI was cut short by i_cpie.
- cfg_err  out  1  one-cycle pulse when i_cpib is rejected.
- underrun_cnt  out  16  count of source-mode stall cycles.
- frame_cnt  out  16  count of completed CPIs.

Behaviour:
- Reset values: every output 0, state IDLE, all counters 0.
- All outputs are registered.
- FSM states: IDLE, LOAD, CHIRP, GAP, DONE.
- IDLE:
  - i_cpib with sample_num != 0 and chirp_num != 0 -> LOAD.
  - i_cpib with either value 0 -> stay IDLE, pulse cfg_err.
- LOAD: latch sample_num, chirp_num, chirp_gap and pattern_sel; clear sample_idx, chirp_idx and frame_trunc; go to CHIRP. Config changes mid-CPI have no effect.
- CHIRP:
  - A beat is emitted when pattern_sel = 1, or when pattern_sel = 0 and src_tvalid = 1.
  - src_tready = (state == CHIRP) and latched pattern_sel = 0.
  - Ramp data: {chirp_idx[15:0], sample_idx[15:0]}.
  - sop when sample_idx == 0; eop when sample_idx == sample_num - 1.
  - After the eop beat:
    - last chirp, or abort pending -> DONE;
    - otherwise chirp_gap == 0 -> stay in CHIRP (back-to-back chirps);
    - otherwise -> GAP.
- GAP: count chirp_gap cycles with valid low, then return to CHIRP.
- DONE: pulse frame_done, increment frame_cnt, go to IDLE. busy drops in the same cycle the FSM enters IDLE.
- Latency: first adc_data_valid is registered at the 2nd clock edge after the edge that samples i_cpib (ramp mode, or src_tvalid already high).
- Source stall: in source mode, src_tvalid = 0 while in CHIRP drops adc_data_valid for that cycle and increments underrun_cnt (saturates at 0xFFFF). sop/eop stay attached to the correct beats.
- i_cpib while busy: ignored, no cfg_err.
- i_cpie while busy:
  - sets abort pending;
  - the current chirp always completes through its eop, so a chirp is never truncated;
  - the FSM then goes to DONE and sets frame_trunc.
  - In GAP, i_cpie goes directly to DONE.
- Simultaneous i_cpib and i_cpie in IDLE: i_cpib wins; i_cpie is ignored.
- rst mid-CPI: outputs drop to 0 on the next edge; there is no trailing eop.
- Counters wrap on sample_num/chirp_num at width CNT_W; sample_num = 1 gives sop and eop on the same beat.

Optional Feature:
- Macro ADC_TX_STATS_EN.
- Defined: underrun_cnt and frame_cnt are implemented as described above; both clear on rst only.
- Undefined: both ports are tied to 0, no counter logic is built, and all other behaviour is unchanged.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, LOAD, CHIRP, GAP, DONE);
  - PATTERN_SRC = 0 and PATTERN_RAMP = 1 constants;
  - the default widths.
- One natural sub-module: adc_frame_tx_cnt, a two-level sample/chirp counter with first/last flags, reusable by the row/column transpose stages.

Test Plan:
- Ramp, sample_num = 4, chirp_num = 3, gap = 2, i_cpib -> 12 beats; data 0x0000_0000..0x0002_0003; sop on beats 0/4/8, eop on 3/7/11; 2 idle cycles between chirps; one frame_done; frame_cnt = 1.
- Source mode, sample_num = 8, chirp_num = 1, src_tvalid low for 3 cycles mid-chirp -> 8 beats matching src_tdata in order; underrun_cnt = 3; eop on the 8th beat.
- i_cpie asserted at beat 2 of chirp 0 (sample_num = 4, chirp_num = 5) -> chirp 0 completes through eop; no chirp 1; frame_done; frame_trunc = 1.
- i_cpib with sample_num = 0 -> cfg_err pulse, busy stays 0, no valid.
- Second i_cpib while busy -> ignored; single frame emitted; frame_cnt increments by 1.
- rst asserted mid-chirp -> all outputs 0 on next edge; a following i_cpib restarts a clean frame with sop on beat 0.
